// File: rtl/alu_pkg.sv
// Shared op-code and FSM state definitions for the iterative ALU.
// Imported by alu_iter and alu_shifter.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_XOR  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_ADD  = 4'b0100,
    OP_BGE  = 4'b0101,
    OP_BNE  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_SLL  = 4'b1001,
    OP_LUI  = 4'b1010,
    OP_RSVD = 4'b1011,
    OP_SRL  = 4'b1100,
    OP_BLT  = 4'b1101,
    OP_SLT  = 4'b1110,
    OP_ADDJ = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift unit for alu_iter: one bit per cycle by default, or a single-cycle
// log barrel shifter when ALU_FAST_SHIFT_EN is defined.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  alu_op_e           i_op,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SH_W-1:0]   i_shamt,
  output logic [DATA_W-1:0] o_imm_result,
  output logic              o_imm_done,
  output logic [DATA_W-1:0] o_iter_result,
  output logic              o_iter_last
);

`ifdef ALU_FAST_SHIFT_EN

  logic [DATA_W-1:0] w_stage [SH_W+1];

  assign w_stage[0] = i_data;

  // Stage gi shifts by 2**gi when the matching shamt bit is set.
  for (genvar gi = 0; gi < SH_W; gi++) begin : g_stage
    assign w_stage[gi+1] =
      !i_shamt[gi]       ? w_stage[gi] :
      (i_op == OP_SLL)   ? (w_stage[gi] << (2**gi)) :
      (i_op == OP_SRA)   ? $unsigned($signed(w_stage[gi]) >>> (2**gi)) :
                           (w_stage[gi] >> (2**gi));
  end

  assign o_imm_result  = w_stage[SH_W];
  assign o_imm_done    = 1'b1;
  assign o_iter_result = '0;
  assign o_iter_last   = 1'b0;

`else

  function automatic logic [DATA_W-1:0] shift1(alu_op_e op, logic [DATA_W-1:0] d);
    case (op)
      OP_SLL:  return {d[DATA_W-2:0], 1'b0};
      OP_SRA:  return {d[DATA_W-1], d[DATA_W-1:1]};
      default: return {1'b0, d[DATA_W-1:1]};
    endcase
  endfunction

  logic [DATA_W-1:0] r_data;
  logic [SH_W-1:0]   r_cnt;
  alu_op_e           r_op;

  // The first bit is shifted on the load edge, so r_cnt counts the remaining bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_op   <= OP_SLL;
    end else if (i_load) begin
      r_op   <= i_op;
      r_data <= shift1(i_op, i_data);
      r_cnt  <= (i_shamt == '0) ? '0 : i_shamt - SH_W'(1);
    end else if (r_cnt != '0) begin
      r_data <= shift1(r_op, r_data);
      r_cnt  <= r_cnt - SH_W'(1);
    end
  end

  assign o_imm_done    = (i_shamt <= SH_W'(1));
  assign o_imm_result  = (i_shamt == '0) ? i_data : shift1(i_op, i_data);
  assign o_iter_result = shift1(r_op, r_data);
  assign o_iter_last   = (r_cnt == SH_W'(1));

`endif

endmodule

// File: rtl/alu_iter.sv
// Handshaked RISC-V style ALU with a multi-cycle shift path (IDLE/SHIFT/DONE).
// Define ALU_FAST_SHIFT_EN to make shifts single-cycle.
module alu_iter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic              zero,
  output logic              busy
);

  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            r_state;
  state_e            w_state_next;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;

  alu_op_e           w_op;
  logic              w_accept;
  logic              w_is_shift;
  logic              w_direct;
  logic              w_lt;
  logic              w_eq;
  logic              w_cond;
  logic              w_is_branch;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_zero;

  logic [DATA_W-1:0] w_sh_imm_result;
  logic              w_sh_imm_done;
  logic [DATA_W-1:0] w_sh_iter_result;
  logic              w_sh_iter_last;

  assign w_op       = alu_op_e'(Operation);
  assign w_accept   = in_valid && in_ready;
  assign w_is_shift = is_shift(w_op);
  // Everything except a shift longer than one bit completes on the accept edge.
  assign w_direct   = !w_is_shift || w_sh_imm_done;
  assign w_lt       = $signed(SrcA) < $signed(SrcB);
  assign w_eq       = (SrcA == SrcB);

  alu_shifter #(
    .DATA_W(DATA_W),
    .SH_W  (SH_W)
  ) u_shifter (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_accept && w_is_shift),
    .i_op         (w_op),
    .i_data       (SrcA),
    .i_shamt      (SrcB[SH_W-1:0]),
    .o_imm_result (w_sh_imm_result),
    .o_imm_done   (w_sh_imm_done),
    .o_iter_result(w_sh_iter_result),
    .o_iter_last  (w_sh_iter_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_direct ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_sh_iter_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          w_state_next = w_direct ? S_DONE : S_SHIFT;
        end else if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !reset && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  always_comb begin
    w_alu_result = '0;
    w_cond       = 1'b0;
    w_is_branch  = 1'b0;
    case (w_op)
      OP_AND:          w_alu_result = SrcA & SrcB;
      OP_XOR:          w_alu_result = SrcA ^ SrcB;
      OP_SUB:          w_alu_result = SrcA - SrcB;
      OP_OR:           w_alu_result = SrcA | SrcB;
      OP_ADD, OP_ADDJ: w_alu_result = SrcA + SrcB;
      OP_LUI:          w_alu_result = SrcB;
      OP_SLT:          w_alu_result = {{(DATA_W-1){1'b0}}, w_lt};
      OP_SLL, OP_SRL, OP_SRA: w_alu_result = w_sh_imm_result;
      OP_BEQ: begin w_is_branch = 1'b1; w_cond = w_eq;  end
      OP_BNE: begin w_is_branch = 1'b1; w_cond = !w_eq; end
      OP_BLT: begin w_is_branch = 1'b1; w_cond = w_lt;  end
      OP_BGE: begin w_is_branch = 1'b1; w_cond = !w_lt; end
      default:         w_alu_result = '0;
    endcase
    if (w_is_branch) begin
      w_alu_result = {{(DATA_W-1){1'b0}}, w_cond};
    end
    // The reserved code yields 0, so its zero flag comes out as 1 naturally.
    w_alu_zero = w_is_branch ? w_cond : (w_alu_result == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept && w_direct) begin
      r_result <= w_alu_result;
      r_zero   <= w_alu_zero;
    end else if ((r_state == S_SHIFT) && w_sh_iter_last) begin
      r_result <= w_sh_iter_result;
      r_zero   <= (w_sh_iter_result == '0);
    end
  end

  assign ALUResult = r_result;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: directed vectors push expectations,
// a monitor pops and compares on every out_valid && out_ready transfer.
module tb_alu_iter;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        zero;
  logic        busy;

  alu_iter #(.DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Operation(Operation),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUResult(ALUResult),
    .zero     (zero),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  exp_t  sb_q[$];
  string tag_q[$];
  vec_t  vecs[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic void add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] r, input logic z, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.r = r; v.z = z; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Drive a request at a negedge, wait for in_ready, push the expectation on accept.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input logic z,
                       input logic ordy);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    out_ready = ordy;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      @(posedge clk);
      e.r = r;
      e.z = z;
      sb_q.push_back(e);
      tag_q.push_back(tag);
      #1;
    end
    in_valid  = 1'b0;
    Operation = 4'h0;
    SrcA      = 32'hA5A5_A5A5;
    SrcB      = 32'h5A5A_5A5A;
  endtask

  // Count edges from the accept edge until out_valid; busy must stay high meanwhile.
  task automatic wait_valid(input string tag, input int exp_lat);
    int   lat;
    logic busy_all;
    lat      = 1;
    busy_all = 1'b1;
    @(negedge clk);
    #1;
    while (!out_valid && lat < 200) begin
      busy_all = busy_all & busy;
      @(negedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    if (exp_lat > 1) chk({tag, "_busy"}, {31'd0, busy_all}, 32'd1);
  endtask

  // Monitor: one comparison pair per completed output transfer.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=%h required=no_output", ALUResult);
        end else begin
          e = sb_q.pop_front();
          t = tag_q.pop_front();
          chk({t, "_result"}, ALUResult, e.r);
          chk({t, "_zero"}, {31'd0, zero}, {31'd0, e.z});
          $display("txn %s result=%h zero=%0d", t, ALUResult, zero);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Operation = 4'h0;
    SrcA      = '0;
    SrcB      = '0;

    add_vec(4'b0000, 32'h0F0F_00FF, 32'h00FF_0F0F, 32'h000F_000F, 1'b0, 1);
    add_vec(4'b0001, 32'h0F0F_00FF, 32'h00FF_0F0F, 32'h0FF0_0FF0, 1'b0, 1);
    add_vec(4'b0010, 32'h0F0F_00FF, 32'h00FF_0F0F, 32'h0E0F_F1F0, 1'b0, 1);
    add_vec(4'b0011, 32'h0F0F_00FF, 32'h00FF_0F0F, 32'h0FFF_0FFF, 1'b0, 1);
    add_vec(4'b0100, 32'h0F0F_00FF, 32'h00FF_0F0F, 32'h100E_100E, 1'b0, 1);
    add_vec(4'b1111, 32'h0000_1000, 32'hFFFF_F000, 32'h0000_0000, 1'b1, 1);
    add_vec(4'b1010, 32'h0000_0123, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 1);
    add_vec(4'b1110, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
    add_vec(4'b1110, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0000, 1'b1, 1);
    add_vec(4'b1000, 32'h0000_0007, 32'h0000_0007, 32'h0000_0001, 1'b1, 1);
    add_vec(4'b0110, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b0, 1);
    add_vec(4'b1101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 1);
    add_vec(4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
    add_vec(4'b0101, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1'b1, 1);
    add_vec(4'b1101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1);
    add_vec(4'b1011, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1);
    add_vec(4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 4);
    add_vec(4'b0111, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1);
    add_vec(4'b0111, 32'h4000_0000, 32'h0000_0002, 32'h1000_0000, 1'b0, 2);
    add_vec(4'b0111, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 31);
    add_vec(4'b1100, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 31);
    add_vec(4'b1100, 32'h0000_00F0, 32'h0000_0004, 32'h0000_000F, 1'b0, 4);
    add_vec(4'b1100, 32'h0000_0003, 32'h0000_0002, 32'h0000_0000, 1'b1, 2);
    add_vec(4'b1001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1);
    add_vec(4'b1001, 32'hFFFF_FFFF, 32'h0000_001F, 32'h8000_0000, 1'b0, 31);

    // Reset state, then release.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_result",    ALUResult,          32'd0);
    chk("rst_zero",      {31'd0, zero},      32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    issue("add_ovf", 4'b0100, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    wait_valid("add_ovf", 1);

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d_op%h", i, vecs[i].op);
      issue(t, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].z, 1'b1);
      wait_valid(t, vecs[i].lat);
    end

    // Stalled consumer: result held, new request ignored until out_ready.
    issue("sub_hold", 4'b0010, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
    wait_valid("sub_hold", 1);
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = 4'b0001;
    SrcA      = 32'h0000_00FF;
    SrcB      = 32'h0000_000F;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      chk($sformatf("hold%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_result", k),    ALUResult,          32'd0);
      chk($sformatf("hold%0d_zero", k),      {31'd0, zero},      32'd1);
      chk($sformatf("hold%0d_in_ready", k),  {31'd0, in_ready},  32'd0);
    end
    // Back-to-back: release out_ready with the pending request still presented.
    issue("b2b_xor", 4'b0001, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0, 1'b1);
    wait_valid("b2b_xor", 1);

    // Reset in the middle of a long shift discards it.
    issue("sll_abort", 4'b1001, 32'h0000_0001, 32'd20, 32'h0010_0000, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    tag_q.delete();
    @(negedge clk);
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy",      {31'd0, busy},      32'd0);
    chk("abort_result",    ALUResult,          32'd0);
    chk("abort_in_ready",  {31'd0, in_ready},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_release_in_ready", {31'd0, in_ready}, 32'd1);
    issue("post_abort_and", 4'b0000, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0, 1'b1);
    wait_valid("post_abort_and", 1);
    issue("post_abort_sll", 4'b1001, 32'h0000_0003, 32'd3, 32'h0000_0018, 1'b0, 1'b1);
    wait_valid("post_abort_sll", 3);

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
